// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for pipeline stage registers: the skid-buffer state encoding
// and the stage payload structs that get packed into a stage register.
package pipe_skid_reg_pkg;

    // Skid-buffer occupancy state; the encoding doubles as the beat count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Memory -> writeback stage payload.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
        logic [25:0] pc_lo;
    } memory_data_t;

    // Writeback -> retire payload.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
    } writeback_data_t;

    // Instantiating code sets WIDTH from these so the register always
    // matches the struct it carries.
    function automatic int memory_data_bits();
        return $bits(memory_data_t);
    endfunction

    function automatic int writeback_data_bits();
        return $bits(writeback_data_t);
    endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used for performance monitoring; sticks at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;

    // Count qualifying cycles; hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages. Outputs decode from the
// state register only, so in_ready never depends on out_ready in the same
// cycle. out_data always comes from the main register; the skid register
// catches the beat accepted while downstream was stalling.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int CNT_WIDTH    = 32,
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    // Handshake outputs are pure functions of the state register.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        unique case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // Next state and data moves; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_POP) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        if (CLEAR_ON_POP) main_d = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        if (CLEAR_ON_POP) skid_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and data registers; reset drops any held beats immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule
